// File: rtl/vfifo_rd_ctrl_if.sv
// Read-side bundle of the versatile FIFO: RAM port B address/data plus the
// valid/ready output stream.
interface vfifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] adr_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output adr_b,
    input  q_b,
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  adr_b,
    output q_b,
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/vfifo_rd_ctrl.sv
// Read-domain controller for the versatile FIFO: issues RAM port B reads, hides
// the one-cycle q_b latency behind a 2-entry skid buffer, returns a Gray rptr.
module vfifo_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  vfifo_rd_ctrl_if.master       bus,
  output logic [ADDR_WIDTH:0]   rptr_gray_o,
  output logic [ADDR_WIDTH:0]   ram_level,
  output logic                  empty
);

  logic [ADDR_WIDTH:0]   wptr_bin;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   rptr_gray_q;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_idx_q, rd_idx_d;
  logic                  wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] obuf_q [0:1];

  logic       ram_empty;
  logic       pop;
  logic       issue;
  logic [2:0] fill;

  generate
    for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
      assign wptr_bin[gi] = ^wptr_gray_i[ADDR_WIDTH:gi];
    end
  endgenerate

  assign bus.adr_b      = rptr_q[ADDR_WIDTH-1:0];
  assign bus.dout       = obuf_q[rd_idx_q];
  assign bus.dout_valid = (occ_q != 2'd0);
  assign rptr_gray_o    = rptr_gray_q;
  assign ram_level      = wptr_bin - rptr_q;
  assign empty          = ram_empty & ~inflight_q & (occ_q == 2'd0);

  always_comb begin
    ram_empty  = (rptr_q == wptr_bin);
    pop        = bus.dout_valid & bus.dout_ready;
    fill       = {1'b0, occ_q} + {2'b00, inflight_q};
    // A pop frees a slot on the same edge the issued word will need it.
    issue      = ~ram_empty & ((fill < 3'd2) | pop);
    rptr_d     = issue ? rptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1} : rptr_q;
    inflight_d = issue;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_idx_d   = inflight_q ? ~wr_idx_q : wr_idx_q;
    rd_idx_d   = pop ? ~rd_idx_q : rd_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q      <= '0;
      rptr_gray_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      rd_idx_q    <= 1'b0;
      wr_idx_q    <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      rptr_gray_q <= rptr_q ^ (rptr_q >> 1);
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  // Data storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) begin
      obuf_q[wr_idx_q] <= bus.q_b;
    end
  end

endmodule

// File: tb/tb_vfifo_rd_ctrl.sv
// Scoreboard bench for vfifo_rd_ctrl: a wide instance for latency, burst,
// backpressure and reset, plus a 4-deep instance for pointer wrap.
module tb_vfifo_rd_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int AW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AW:0]  wptr_gray, rptr_gray, ram_level;
  logic         empty;
  logic [AW2:0] wptr2, rptr_gray2, ram_level2;
  logic         empty2;

  vfifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW))  bus ();
  vfifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2)) bus2 ();

  vfifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wptr_gray_i(wptr_gray), .bus(bus),
    .rptr_gray_o(rptr_gray), .ram_level(ram_level), .empty(empty)
  );

  vfifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2)) dut2 (
    .clk(clk), .rst(rst), .wptr_gray_i(wptr2), .bus(bus2),
    .rptr_gray_o(rptr_gray2), .ram_level(ram_level2), .empty(empty2)
  );

  logic [DW-1:0] mem  [0:255];
  logic [DW-1:0] mem2 [0:3];
  always @(posedge clk) bus.q_b  <= mem[bus.adr_b];
  always @(posedge clk) bus2.q_b <= mem2[bus2.adr_b];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] exp2_q [$];
  int wcnt = 0, pop_cnt = 0;
  int w2cnt = 0, pop2_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [AW:0] gray9(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW2:0] gray3(input logic [AW2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW2:0] g2b3(input logic [AW2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  // Monitors: every accepted word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.dout_valid && bus.dout_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dout_extra got %h want none", bus.dout);
      end else begin
        check("dout", bus.dout, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus2.dout_valid && bus2.dout_ready) begin
      pop2_cnt++;
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dout2_extra got %h want none", bus2.dout);
      end else begin
        check("dout2", bus2.dout, exp2_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic publish(input logic [DW-1:0] d);
    logic [AW:0] b;
    mem[wcnt % 256] = d;
    exp_q.push_back(d);
    wcnt++;
    b = wcnt[AW:0];
    wptr_gray = gray9(b);
    $display("publish word %h wptr_gray %h", d, wptr_gray);
  endtask

  task automatic publish2(input logic [DW-1:0] d);
    logic [AW2:0] b;
    mem2[w2cnt % 4] = d;
    exp2_q.push_back(d);
    w2cnt++;
    b = w2cnt[AW2:0];
    wptr2 = gray3(b);
    $display("publish2 word %h wptr2 %h", d, wptr2);
  endtask

  function automatic logic space2();
    logic [AW2:0] wb;
    logic [AW2:0] diff;
    wb   = w2cnt[AW2:0];
    diff = wb - g2b3(rptr_gray2);
    return diff < 3'd4;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    wptr_gray = '0;
    wcnt = 0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  vb5;
    logic [11:0] vb12;
    int base, outst;

    rst = 1'b1;
    wptr_gray = '0;
    wptr2 = '0;
    bus.dout_ready = 1'b0;
    bus2.dout_ready = 1'b0;

    // Reset state and single-word latency.
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rgray", 32'(rptr_gray), 32'd0);
    check("rst_level", 32'(ram_level), 32'd0);
    tick();
    bus.dout_ready = 1'b1;
    vb5 = '0;
    publish(32'hA5A5_0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vb5[i] = bus.dout_valid;
      if (i == 0) check("single_adr", 32'(bus.adr_b), 32'd0);
      if (i == 2) check("single_empty_busy", 32'(empty), 32'd0);
      tick();
    end
    check("single_latency", 32'(vb5), 32'h4);
    check("single_empty_after", 32'(empty), 32'd1);
    check("single_rgray", 32'(rptr_gray), 32'h1);

    // Burst of 8 with ready held high: valid cycles 2..9, no gaps.
    do_reset();
    bus.dout_ready = 1'b1;
    vb12 = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) publish(32'h0000_0000 + 32'(i));
      @(negedge clk);
      vb12[i] = bus.dout_valid;
      tick();
    end
    check("burst_valid_pattern", 32'(vb12), 32'h3FC);
    check("burst_rgray", 32'(rptr_gray), 32'h00C);
    check("burst_empty", 32'(empty), 32'd1);

    // Backpressure: two words buffered, head held, then toggled ready.
    do_reset();
    bus.dout_ready = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      publish(32'hC0DE_0000 + 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
      check("bp_hold_dout", bus.dout, 32'hC0DE_0000);
      tick();
    end
    check("bp_rgray", 32'(rptr_gray), 32'h003);
    check("bp_level", 32'(ram_level), 32'd6);
    for (int c = 0; c < 64 && exp_q.size() != 0; c++) begin
      bus.dout_ready = (c % 2 == 0);
      tick();
      outst = (wcnt - int'(ram_level)) - (pop_cnt - base);
      check("bp_outstanding_le2", 32'(outst <= 2), 32'd1);
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_pops", 32'(pop_cnt - base), 32'd8);
    check("bp_empty", 32'(empty), 32'd1);

    // Reset in the middle of a transfer, then a fresh refill.
    do_reset();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      publish(32'hDEAD_0000 + 32'(i));
      tick();
    end
    rst = 1'b1;
    wptr_gray = '0;
    wcnt = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_rgray", 32'(rptr_gray), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    tick();
    base = pop_cnt;
    bus.dout_ready = 1'b1;
    publish(32'hBEEF_0001);
    tick();
    publish(32'hBEEF_0002);
    tick();
    drain("midrst_drain", 20);
    check("midrst_pops", 32'(pop_cnt - base), 32'd2);

    // Wrap on the 4-deep instance: fill to full, then stream 20 words.
    bus2.dout_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (space2()) publish2(32'h7000_0000 + 32'(w2cnt));
      tick();
    end
    check("wrap_full_level", 32'(ram_level2), 32'd4);
    bus2.dout_ready = 1'b1;
    for (int c = 0; c < 200 && (w2cnt < 20 || exp2_q.size() != 0); c++) begin
      if (w2cnt < 20 && space2()) publish2(32'h7000_0000 + 32'(w2cnt));
      tick();
    end
    check("wrap_drained", 32'(exp2_q.size()), 32'd0);
    check("wrap_pops", 32'(pop2_cnt), 32'd20);
    check("wrap_empty", 32'(empty2), 32'd1);
    check("wrap_rgray", 32'(rptr_gray2), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vfifo_rd_ctrl.md
Name: vfifo_rd_ctrl

Overview:
- Read-side controller for a versatile FIFO built on the dual-port, dual-clock RAM.
- Lives entirely in the read clock domain and drives the RAM's port B address. It absorbs the one-cycle registered read latency of q_b and presents a valid/ready stream with full throughput.
- Returns a Gray-coded read pointer for synchronisation back into the write domain. Counterpart of the write-side controller.

Parameters:
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 8, RAM address width; depth = 2^ADDR_WIDTH.

Ports:
- clk, input, 1, read-domain clock.
- rst, input, 1, synchronous active-high reset.
- wptr_gray_i, input, ADDR_WIDTH+1, write pointer, Gray code, already synchronised into clk.
- adr_b, output, ADDR_WIDTH, RAM port B address.
- q_b, input, DATA_WIDTH, RAM port B read data; reflects the adr_b sampled at the previous edge.
- dout, output, DATA_WIDTH, output stream data.
- dout_valid, output, 1, dout holds a word.
- dout_ready, input, 1, consumer accepts the word.
- rptr_gray_o, output, ADDR_WIDTH+1, registered Gray read pointer, sent to the write domain.
- ram_level, output, ADDR_WIDTH+1, words in RAM not yet issued.
- empty, output, 1, nothing in RAM, in flight, or buffered.

Behaviour:
- Pointers:
  - wptr_bin = Gray-to-binary of wptr_gray_i, where bit i = XOR of gray[ADDR_WIDTH:i]. Combinational.
  - rptr is a binary register of ADDR_WIDTH+1 bits. The MSB is the wrap bit; increment is modulo 2^(ADDR_WIDTH+1).
  - adr_b = rptr[ADDR_WIDTH-1:0], driven directly from the register.
  - ram_empty = (rptr == wptr_bin).
  - ram_level = wptr_bin - rptr, modulo 2^(ADDR_WIDTH+1). Combinational.
- State:
  - inflight: 1 bit; a RAM read was issued last cycle.
  - Output buffer: 2-entry FIFO of DATA_WIDTH words; occ ranges 0..2.
- Handshake:
  - pop = dout_valid & dout_ready.
  - dout = buffer head.
  - dout_valid = (occ != 0).
  - dout is held stable while dout_valid & !dout_ready.
- Issue:
  - issue = !ram_empty & ((occ + inflight < 2) | pop).
  - On issue, rptr increments and inflight is set next cycle; otherwise inflight clears.
  - The RAM latches adr_b (the old rptr) on the same edge.
- Capture:
  - When inflight = 1, q_b is written into the buffer tail on that edge.
  - Capture and pop in the same cycle: occ is unchanged and order is preserved.
- Latency:
  - Word visible in RAM (ram_empty falls) at cycle n -> issue at n -> captured at n+1 edge -> dout_valid at n+2. Two cycles latency, with an empty buffer.
  - Sustained throughput is 1 word/cycle while dout_ready = 1 and the RAM is non-empty.
- Backpressure: with dout_ready = 0, at most 2 words are buffered plus 0 in flight. The invariant occ + inflight <= 2 is never violated, and no word is lost or duplicated.
- rptr_gray_o:
  - Registered: rptr_gray_o <= rptr ^ (rptr >> 1), one cycle after rptr changes.
  - A slot is released to the writer at issue time. This is safe because q_b has already latched before the write domain can observe the release: at least 1 register cycle plus its synchroniser.
- empty = ram_empty & !inflight & (occ == 0).
- Wrap:
  - The pointer wraps naturally from 2^(ADDR_WIDTH+1)-1 to 0.
  - A full RAM (ram_level = 2^ADDR_WIDTH) is handled identically; no special case.
- Input constraint: wptr_gray_i changes by at most one Gray step per sample and only after the RAM write completes. The block does not check this.
- Reset (synchronous, highest priority, including mid-transfer):
  - rptr = 0, rptr_gray_o = 0, inflight = 0, occ = 0.
  - dout_valid = 0, empty = 1 (given wptr = 0).
  - dout value is don't-care.
  - An in-flight q_b on the reset edge is discarded.

Test Plan:
- Reset and single word: assert rst 2 cycles with wptr_gray_i = 0 -> dout_valid = 0, empty = 1, rptr_gray_o = 0. Write word 0xA5A5_0001 at address 0, set wptr_gray_i = 1 at cycle n -> adr_b = 0 at n, dout_valid = 1 with dout = 0xA5A5_0001 at n+2, empty = 0. Hold dout_ready = 1 -> rptr_gray_o = 1, empty = 1 afterwards.
- Burst: preload 8 words (0..7), step wptr_gray_i to Gray(8) in one-step increments, dout_ready = 1 -> 8 consecutive valid cycles delivering 0..7 in order, no gaps after the first, final rptr_gray_o = 0x0C.
- Backpressure: 8 words present, dout_ready = 0 -> rptr advances by exactly 2, dout = word 0 held stable. Then toggle dout_ready 1,0,1,... -> all 8 words delivered in order, none duplicated, occ + inflight never exceeds 2.
- Wrap (ADDR_WIDTH = 2): stream 20 words through with the writer keeping ram_level <= 4 -> rptr wraps 7 -> 0 twice, data sequence intact, ram_level = 4 correctly reported when full.
- Reset mid-operation: 3 words buffered/in flight, assert rst for 1 cycle -> next cycle dout_valid = 0, rptr_gray_o = 0, no stale word emitted after a fresh refill.
